// File: rtl/edge_pulse_gen_pkg.sv
// Shared types and parameter limits for the edge pulse generator.
// Channels take their mode as edge_mode_t; the top checks parameters with params_ok.
package edge_pulse_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } edge_mode_t;

  localparam int N_CH_MIN        = 1;
  localparam int N_CH_MAX        = 32;
  localparam int SYNC_STAGES_MIN = 0;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int PULSE_LEN_MIN   = 1;
  localparam int PULSE_LEN_MAX   = 255;

  function automatic bit params_ok(int n_ch, int sync_stages, int pulse_len);
    return (n_ch >= N_CH_MIN) && (n_ch <= N_CH_MAX) &&
           (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
           (pulse_len >= PULSE_LEN_MIN) && (pulse_len <= PULSE_LEN_MAX);
  endfunction

endpackage

// File: rtl/edge_pulse_gen_if.sv
// Channel bundle between a controller (master) and the pulse generator (slave).
// The mode field holds one 2-bit edge_mode_t per channel, channel 0 in the low bits.
interface edge_pulse_gen_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]   s;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   ack;
  logic [N_CH-1:0]   p;
  logic [N_CH-1:0]   pend;
  logic              any_pend;

  modport master (output s, mode, ack, input p, pend, any_pend);
  modport slave  (input s, mode, ack, output p, pend, any_pend);
endinterface

// File: rtl/edge_pulse_gen_ch.sv
// One edge-detect channel: synchroniser, prev/primed tracking, pulse counter, sticky pend.
module edge_pulse_ch
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s,
  input  edge_mode_t mode,
  input  logic       ack,
  output logic       p,
  output logic       pend
);
  localparam int CW = $clog2(PULSE_LEN + 1);

  logic          sampled;
  logic          sampled_vld;
  logic          prev_q, prev_d;
  logic          primed_q, primed_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          det;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign sampled     = s;
      assign sampled_vld = 1'b1;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [SYNC_STAGES-1:0] vld_q, vld_d;

      // vld marks chain stages that hold a real post-reset sample, so a level
      // held through reset is not mistaken for an edge from the cleared chain.
      always_comb begin
        sync_d = SYNC_STAGES'({sync_q, s});
        vld_d  = SYNC_STAGES'({vld_q, 1'b1});
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
          vld_q  <= '0;
        end else begin
          sync_q <= sync_d;
          vld_q  <= vld_d;
        end
      end

      assign sampled     = sync_q[SYNC_STAGES-1];
      assign sampled_vld = vld_q[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    det = 1'b0;
    if (primed_q) begin
      if ((mode == RISE || mode == BOTH) && sampled && !prev_q) det = 1'b1;
      if ((mode == FALL || mode == BOTH) && !sampled && prev_q) det = 1'b1;
    end

    prev_d   = sampled;
    primed_d = primed_q | sampled_vld;

    cnt_d = cnt_q;
    if (det)               cnt_d = CW'(PULSE_LEN);
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;

    pend_d = pend_q;
    if (det)      pend_d = 1'b1;
    else if (ack) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
    end
  end

  assign p    = (cnt_q != '0);
  assign pend = pend_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator: N_CH independent channels plus a
// registered any_pend summary.
module edge_pulse_gen
  import edge_pulse_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1
) (
  input logic              clk,
  input logic              rst_n,
  edge_pulse_gen_if.slave  bus
);
  generate
    if (!params_ok(N_CH, SYNC_STAGES, PULSE_LEN)) begin : g_param_err
      $fatal(1, "edge_pulse_gen: illegal N_CH/SYNC_STAGES/PULSE_LEN");
    end
  endgenerate

  logic [N_CH-1:0] p_w;
  logic [N_CH-1:0] pend_w;
  logic            any_pend_q, any_pend_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_pulse_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .PULSE_LEN   (PULSE_LEN)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (bus.s[i]),
      .mode  (edge_mode_t'(bus.mode[2*i +: 2])),
      .ack   (bus.ack[i]),
      .p     (p_w[i]),
      .pend  (pend_w[i])
    );
  end

  always_comb begin
    any_pend_d = |pend_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_pend_q <= 1'b0;
    else        any_pend_q <= any_pend_d;
  end

  assign bus.p        = p_w;
  assign bus.pend     = pend_w;
  assign bus.any_pend = any_pend_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Scoreboard bench for edge_pulse_gen: three configurations share clk and rst_n;
// expected per-cycle values are queued with their cycle number and checked after each edge.
module tb_edge_pulse_gen;
  import edge_pulse_pkg::*;

  localparam int DA = 0, DB = 1, DC = 2;
  localparam int F_P = 0, F_PEND = 1, F_ANY = 2;

  typedef struct {
    int    cyc;
    int    dut;
    int    fld;
    int    ch;
    logic  val;
    string tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_total;
  int   n_bad;
  exp_t sb[$];

  edge_pulse_gen_if #(.N_CH(4)) if_a ();
  edge_pulse_gen_if #(.N_CH(4)) if_b ();
  edge_pulse_gen_if #(.N_CH(2)) if_c ();

  edge_pulse_gen #(.N_CH(4), .SYNC_STAGES(2), .PULSE_LEN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  edge_pulse_gen #(.N_CH(4), .SYNC_STAGES(0), .PULSE_LEN(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));
  edge_pulse_gen #(.N_CH(2), .SYNC_STAGES(2), .PULSE_LEN(8)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_obs(input int d, input int f, input int ch);
    logic v;
    v = 1'bx;
    case (d)
      DA: case (f) F_P: v = if_a.p[ch]; F_PEND: v = if_a.pend[ch]; default: v = if_a.any_pend; endcase
      DB: case (f) F_P: v = if_b.p[ch]; F_PEND: v = if_b.pend[ch]; default: v = if_b.any_pend; endcase
      default: case (f) F_P: v = if_c.p[ch]; F_PEND: v = if_c.pend[ch]; default: v = if_c.any_pend; endcase
    endcase
    return v;
  endfunction

  task automatic push(input int c, input int d, input int f, input int ch, input logic v, input string tag);
    exp_t e;
    int   idx;
    e.cyc = c; e.dut = d; e.fld = f; e.ch = ch; e.val = v; e.tag = tag;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk($sformatf("%s@%0d", e.tag, e.cyc), {31'd0, get_obs(e.dut, e.fld, e.ch)}, {31'd0, e.val});
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_defaults();
    if_a.s = '0; if_a.ack = '0;
    if_b.s = '0; if_b.ack = '0;
    if_c.s = '0; if_c.ack = '0;
    if_a.mode = {RISE, FALL, RISE, RISE};
    if_b.mode = {OFF, OFF, BOTH, OFF};
    if_c.mode = {OFF, RISE};
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_p",    {28'd0, if_a.p},    32'd0);
    chk("rst_a_pend", {28'd0, if_a.pend}, 32'd0);
    chk("rst_a_any",  {31'd0, if_a.any_pend}, 32'd0);
    chk("rst_b_p",    {28'd0, if_b.p},    32'd0);
    chk("rst_c_pend", {30'd0, if_c.pend}, 32'd0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic end_scenario(input string name);
    chk({name, "_sb_left"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    set_defaults();

    // basic rise detection with two-stage synchroniser, falling edge ignored
    do_reset();
    push(11, DA, F_P, 0, 1'b0, "s1_p_pre");
    push(12, DA, F_P, 0, 1'b1, "s1_p");
    push(13, DA, F_P, 0, 1'b0, "s1_p_end");
    push(11, DA, F_PEND, 0, 1'b0, "s1_pend_pre");
    push(12, DA, F_PEND, 0, 1'b1, "s1_pend");
    push(12, DA, F_ANY, 0, 1'b0, "s1_any_pre");
    push(13, DA, F_ANY, 0, 1'b1, "s1_any");
    run_to(9);
    if_a.s[0] = 1'b1;
    for (int c = 30; c <= 34; c++) push(c, DA, F_P, 0, 1'b0, "s1_nofall");
    push(34, DA, F_PEND, 0, 1'b1, "s1_pend_sticky");
    run_to(29);
    if_a.s[0] = 1'b0;
    run_to(35);
    end_scenario("s1");

    // direct sampling, BOTH edges, retrigger merges into one long pulse
    set_defaults();
    do_reset();
    push(4, DB, F_P, 1, 1'b0, "s2_p_pre");
    run_to(4);
    if_b.s[1] = 1'b1;
    for (int c = 5; c <= 10; c++) push(c, DB, F_P, 1, 1'b1, "s2_p");
    push(11, DB, F_P, 1, 1'b0, "s2_p_end");
    push(5, DB, F_PEND, 1, 1'b1, "s2_pend");
    push(12, DB, F_ANY, 1, 1'b1, "s2_any");
    run_to(6);
    if_b.s[1] = 1'b0;
    run_to(12);
    end_scenario("s2");

    // ch2 FALL held high through reset; ch3 ack/detect collision
    set_defaults();
    if_a.s[2] = 1'b1;
    do_reset();
    for (int c = 1; c <= 8; c++) push(c, DA, F_P, 2, 1'b0, "s3_norel");
    push(19, DA, F_PEND, 2, 1'b0, "s3_pend_pre");
    run_to(4);
    if_a.s[3] = 1'b1;
    push(7, DA, F_P, 3, 1'b1, "s4_p1");
    push(7, DA, F_PEND, 3, 1'b1, "s4_pend1");
    push(8, DA, F_ANY, 0, 1'b1, "s4_any1");
    run_to(8);
    if_a.s[3] = 1'b0;
    run_to(11);
    if_a.s[3] = 1'b1;
    push(13, DA, F_PEND, 3, 1'b1, "s4_pend_hold");
    push(14, DA, F_P, 3, 1'b1, "s4_p2");
    push(14, DA, F_PEND, 3, 1'b1, "s4_set_wins");
    push(15, DA, F_P, 3, 1'b0, "s4_p2_end");
    push(15, DA, F_PEND, 3, 1'b0, "s4_ack_clr");
    push(15, DA, F_ANY, 0, 1'b1, "s4_any_lag");
    push(16, DA, F_ANY, 0, 1'b0, "s4_any_clr");
    run_to(13);
    if_a.ack[3] = 1'b1;
    run_to(15);
    if_a.ack[3] = 1'b0;
    run_to(19);
    if_a.s[2] = 1'b0;
    push(21, DA, F_P, 2, 1'b0, "s3_p_pre");
    push(22, DA, F_P, 2, 1'b1, "s3_p");
    push(23, DA, F_P, 2, 1'b0, "s3_p_end");
    push(22, DA, F_PEND, 2, 1'b1, "s3_pend");
    run_to(24);
    end_scenario("s34");

    // long pulse cut by reset, no resumed pulse with level held high
    set_defaults();
    do_reset();
    run_to(2);
    if_c.s[0] = 1'b1;
    push(4, DC, F_P, 0, 1'b0, "s5_p_pre");
    for (int c = 5; c <= 7; c++) push(c, DC, F_P, 0, 1'b1, "s5_p");
    push(5, DC, F_PEND, 0, 1'b1, "s5_pend");
    run_to(7);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_p",    {31'd0, if_c.p[0]},    32'd0);
    chk("s5_rst_pend", {31'd0, if_c.pend[0]}, 32'd0);
    chk("s5_rst_any",  {31'd0, if_c.any_pend}, 32'd0);
    chk("s5_rst_cnt",  {28'd0, u_c.g_ch[0].u_ch.cnt_q}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 14; c++) push(c, DC, F_P, 0, 1'b0, "s5_noresume");
    push(14, DC, F_PEND, 0, 1'b0, "s5_nopend");
    run_to(14);
    end_scenario("s5");

    // OFF across an edge, back to RISE with stable level, then a real rise
    set_defaults();
    do_reset();
    run_to(3);
    if_a.mode[1:0] = OFF;
    for (int c = 10; c <= 22; c++) push(c, DA, F_P, 0, 1'b0, "s6_nopulse");
    push(22, DA, F_PEND, 0, 1'b0, "s6_nopend");
    run_to(9);
    if_a.s[0] = 1'b1;
    run_to(16);
    if_a.mode[1:0] = RISE;
    run_to(22);
    if_a.s[0] = 1'b0;
    run_to(25);
    if_a.s[0] = 1'b1;
    push(27, DA, F_P, 0, 1'b0, "s6_p_pre");
    push(28, DA, F_P, 0, 1'b1, "s6_p");
    push(28, DA, F_PEND, 0, 1'b1, "s6_pend");
    run_to(29);
    end_scenario("s6");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_pulse_gen.md
EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

Interface
REQ-001 Parameter N_CH, default 4: channel count, legal 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: input synchroniser depth, legal 0..4; 0 means s is used directly.
REQ-003 Parameter PULSE_LEN, default 1: output pulse length in clk cycles, legal 1..255.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s  input  N_CH  level inputs; may be asynchronous to clk.
REQ-007 mode  input  2*N_CH  per-channel edge_mode_t: OFF, RISE, FALL, BOTH.
REQ-008 ack  input  N_CH  per-channel clear for pend.
REQ-009 p  output  N_CH  per-channel registered pulse.
REQ-010 pend  output  N_CH  per-channel sticky event flag.
REQ-011 any_pend  output  1  registered OR of all pend bits.

Function
REQ-012 Each channel SHALL be independent; none of its state depends on another channel.
REQ-013 Each channel SHALL hold a SYNC_STAGES-deep flop chain; its last stage, or s when SYNC_STAGES=0, is the sampled level.
REQ-014 Each channel SHALL hold a prev register and a primed flag; the first clk edge after reset loads prev, sets primed and detects nothing.
REQ-015 While primed, prev SHALL load the sampled level on every edge, whatever mode is set.
REQ-016 A rise SHALL be sampled=1, prev=0; a fall SHALL be sampled=0, prev=1; detection SHALL apply only when the mode bit for that edge type is set.
REQ-017 Latency: if s changes before edge k and stays stable, p SHALL rise after edge k+SYNC_STAGES.
REQ-018 On detection the channel's pulse counter SHALL load PULSE_LEN and p SHALL be high exactly while the counter is nonzero, giving PULSE_LEN cycles.
REQ-019 A detection while p is high SHALL reload the counter to PULSE_LEN, giving one merged, extended pulse with no low gap.
REQ-020 The counter SHALL be $clog2(PULSE_LEN+1) bits wide and SHALL decrement to 0 without wrap-around.
REQ-021 A detection SHALL set pend on the same edge p rises; pend SHALL stay set until cleared by ack.
REQ-022 ack high with no detection on the same edge SHALL clear pend on that edge.
REQ-023 If ack and a detection fall on the same edge, pend SHALL stay set (the set wins).
REQ-024 ack SHALL NOT affect p or the counter.
REQ-025 A mode change SHALL apply from the next edge; a pulse already running SHALL finish unchanged.
REQ-026 mode=OFF SHALL block new detections while prev keeps tracking, so switching OFF then ON creates no spurious edge.
REQ-027 any_pend SHALL be registered, one cycle behind pend.

Reset
REQ-028 rst_n low SHALL at once clear the sync chains, prev, primed, counters, p, pend and any_pend to 0, including in the middle of a pulse.
REQ-029 When rst_n is released, behaviour SHALL restart from REQ-014; a level held high through reset SHALL NOT produce a pulse.

Structure
REQ-030 Package edge_pulse_pkg SHALL define edge_mode_t (OFF=2'b00, RISE=2'b01, FALL=2'b10, BOTH=2'b11) and the parameter legality limits.
REQ-031 Sub-module edge_pulse_ch SHALL implement one channel; edge_pulse_gen SHALL instantiate N_CH copies in a generate loop and build any_pend.
REQ-032 Illegal parameter values SHALL be rejected at elaboration by an assertion.

Verification
REQ-033 Defaults, ch0 RISE; s[0] low at cycle 1, high at cycle 10, low at cycle 30 -> p[0] high for 1 cycle at cycle 12; pend[0] set at 12; any_pend at 13; no pulse near 30.
REQ-034 PULSE_LEN=4, ch1 BOTH, SYNC_STAGES=0; s[1] toggles at cycles 5 and 7 -> p[1] high continuously from cycle 5 through 10 (retrigger at 7); pend[1] set.
REQ-035 ch2 FALL; s[2] held high through reset release, then low at cycle 20 -> no pulse at release; p[2] pulse at cycle 22.
REQ-036 pend[3] set; ack[3] asserted on the same edge as a new ch3 detection -> pend[3] stays 1; ack[3] alone on the next cycle -> pend[3] 0, any_pend 0 one cycle later.
REQ-037 PULSE_LEN=8; rst_n pulled low on cycle 3 of a pulse -> p, pend and the counter are 0 immediately; no resumed pulse after release.
REQ-038 ch0 toggled to OFF across an s edge, then back to RISE with s stable -> no pulse and no pend.
